// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//
// Packs MIPS-style instruction field bundles into 32-bit instruction words
// for an instruction-memory writer. A session starts with start/length in
// IDLE. In RUN the block accepts exactly `length` legal bundles, encodes each
// one and presents it downstream with its word address (0, 1, 2, ...). The
// session ends with a one-cycle done pulse once the last word is taken.
// Bundles with the illegal format code are consumed, produce no word and set
// a sticky err flag.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start, length      session start request and word count (IDLE only)
//   in_valid/in_ready  field bundle handshake
//   fmt                0=R, 1=I, 2=J, 3=illegal
//   opcode .. inst_index  instruction fields
//   out_valid/out_ready   encoded word handshake
//   out_inst, out_addr    encoded word and its address within the session
//   busy               high while a session is running
//   done               one-cycle pulse at session end
//   err                sticky illegal-format flag
// ---------------------------------------------------------------------------
module inst_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] length,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  fmt,
   input  logic [5:0]  opcode,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  sa,
   input  logic [5:0]  funct,
   input  logic [15:0] immediate,
   input  logic [25:0] inst_index,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [11:0] out_addr,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [1:0] FMT_R   = 2'd0;
   localparam logic [1:0] FMT_I   = 2'd1;
   localparam logic [1:0] FMT_J   = 2'd2;
   localparam logic [1:0] FMT_ILL = 2'd3;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Field packing; fields that the format does not use are ignored.
   function automatic logic [31:0] encode(
      input logic [1:0]  f,
      input logic [5:0]  op,
      input logic [4:0]  f_rs,
      input logic [4:0]  f_rt,
      input logic [4:0]  f_rd,
      input logic [4:0]  f_sa,
      input logic [5:0]  f_funct,
      input logic [15:0] f_imm,
      input logic [25:0] f_index
   );
      logic [31:0] w;
      case (f)
         FMT_R:   w = {op, f_rs, f_rt, f_rd, f_sa, f_funct};
         FMT_I:   w = {op, f_rs, f_rt, f_imm};
         FMT_J:   w = {op, f_index};
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   state_t      state_q,      state_d;
   logic [11:0] length_q,     length_d;
   logic [11:0] accept_cnt_q, accept_cnt_d;
   logic [11:0] emit_cnt_q,   emit_cnt_d;
   logic        out_valid_q,  out_valid_d;
   logic [31:0] out_inst_q,   out_inst_d;
   logic [11:0] out_addr_q,   out_addr_d;
   logic        busy_q,       busy_d;
   logic        done_q,       done_d;
   logic        err_q,        err_d;

   logic in_fire;
   logic in_legal;
   logic out_fire;

   // in_ready is combinational so a word can be replaced in the same cycle
   // it is taken downstream (one word per cycle). Gating with rst keeps the
   // handshake closed during a reset cycle even if the session was running.
   assign in_ready = !rst && (state_q == S_RUN)
                     && (!out_valid_q || out_ready)
                     && (accept_cnt_q < length_q);

   assign in_fire  = in_valid && in_ready;
   assign in_legal = (fmt != FMT_ILL);
   assign out_fire = out_valid_q && out_ready;

   always_comb begin
      state_d      = state_q;
      length_d     = length_q;
      accept_cnt_d = accept_cnt_q;
      emit_cnt_d   = emit_cnt_q;
      out_valid_d  = out_valid_q;
      out_inst_d   = out_inst_q;
      out_addr_d   = out_addr_q;
      err_d        = err_q;
      done_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               length_d     = length;
               accept_cnt_d = 12'd0;
               emit_cnt_d   = 12'd0;
               err_d        = 1'b0;
               // An empty session completes immediately without entering RUN.
               if (length == 12'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end

         S_RUN: begin
            // start is deliberately not looked at here.
            if (out_fire) begin
               out_valid_d = 1'b0;
               emit_cnt_d  = emit_cnt_q + 12'd1;
            end

            if (in_fire) begin
               if (in_legal) begin
                  // Overrides the clear above when a word is taken and a new
                  // one arrives in the same cycle.
                  out_valid_d  = 1'b1;
                  out_inst_d   = encode(fmt, opcode, rs, rt, rd, sa, funct,
                                        immediate, inst_index);
                  out_addr_d   = accept_cnt_q;
                  accept_cnt_d = accept_cnt_q + 12'd1;
               end else begin
                  err_d = 1'b1;
               end
            end

            // The last word can only be in flight once every legal bundle
            // has been accepted, so no new word competes with this exit.
            if (out_fire && ((emit_cnt_q + 12'd1) == length_q)) begin
               state_d     = S_IDLE;
               done_d      = 1'b1;
               out_valid_d = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         length_q     <= 12'd0;
         accept_cnt_q <= 12'd0;
         emit_cnt_q   <= 12'd0;
         out_valid_q  <= 1'b0;
         out_inst_q   <= 32'd0;
         out_addr_q   <= 12'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         length_q     <= length_d;
         accept_cnt_q <= accept_cnt_d;
         emit_cnt_q   <= emit_cnt_d;
         out_valid_q  <= out_valid_d;
         out_inst_q   <= out_inst_d;
         out_addr_q   <= out_addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_inst  = out_inst_q;
   assign out_addr  = out_addr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 start  in  1  begin a load session (sampled in IDLE only).
REQ-004 length  in  12  number of legal words to emit in the session, sampled with start.
REQ-005 in_valid  in  1  field bundle valid.
REQ-006 in_ready  out  1  encoder accepts bundle this cycle.
REQ-007 fmt  in  2  0=R, 1=I, 2=J, 3=illegal.
REQ-008 opcode 6, rs 5, rt 5, rd 5, sa 5, funct 6, immediate 16, inst_index 26  in  instruction fields.
REQ-009 out_valid  out  1  out_inst/out_addr valid.
REQ-010 out_ready  in  1  downstream (instruction memory writer) accepts word.
REQ-011 out_inst  out  32  encoded instruction word.
REQ-012 out_addr  out  12  word address of out_inst within session, from 0.
REQ-013 busy  out  1  high while in RUN.
REQ-014 done  out  1  one-cycle pulse at session end.
REQ-015 err  out  1  sticky illegal-format flag; cleared by rst or accepted start.

Function
REQ-016 States IDLE and RUN only; IDLE after reset.
REQ-017 Encoding SHALL be: R = {opcode,rs,rt,rd,sa,funct}; I = {opcode,rs,rt,immediate}; J = {opcode,inst_index}; unused fields ignored.
REQ-018 IDLE: in_ready=0; start with length>0 -> RUN next cycle, accept_cnt=0, emit_cnt=0, err=0.
REQ-019 IDLE: start with length=0 -> done pulses the next cycle, err cleared, state stays IDLE.
REQ-020 start in RUN SHALL be ignored (no effect on counters, length, err).
REQ-021 RUN: in_ready = (!out_valid || out_ready) && (accept_cnt < length).
REQ-022 Input fire (in_valid && in_ready) with fmt 0-2: out_inst loads encoded word, out_addr loads accept_cnt, out_valid=1 next cycle, accept_cnt+1; latency exactly 1 cycle.
REQ-023 Input fire with fmt=3: bundle consumed, err=1, no output produced, accept_cnt unchanged, out_valid unaffected except by a same-cycle output fire.
REQ-024 Output fire (out_valid && out_ready) with no same-cycle legal input fire: out_valid=0 next cycle; emit_cnt+1.
REQ-025 Simultaneous output fire and legal input fire: out_valid stays 1, new word/address replace old; full throughput of 1 word/cycle.
REQ-026 While out_valid && !out_ready, out_inst and out_addr SHALL hold stable.
REQ-027 Output fire making emit_cnt equal length: next cycle done=1 for one cycle, busy=0, state IDLE, out_valid=0.
REQ-028 Counters 12-bit; length max 4095; no wrap within a session.
REQ-029 busy=1 exactly while state is RUN.

Reset
REQ-030 rst SHALL force IDLE, in_ready=0, out_valid=0, out_inst=0, out_addr=0, busy=0, done=0, err=0, counters=0, overriding all other inputs in that cycle.
REQ-031 rst mid-session SHALL abandon the session; any pending out_valid word is dropped and no done pulse occurs.

Verification
REQ-032 start,length=2; R bundle op=0,rs=1,rt=2,rd=3,sa=0,funct=0x20 then I op=0x08,rs=1,rt=1,imm=0x0004, out_ready=1 -> out_inst 0x00221820 @addr0, 0x20210004 @addr1, back-to-back, then done pulse, busy=0.
REQ-033 length=1; J op=0x02,inst_index=0x0000010, out_ready held 0 for 5 cycles -> out_inst 0x08000010 stable, in_ready=0, no done until out_ready=1.
REQ-034 length=1; fmt=3 bundle then R bundle all-zero -> err=1, single output 0x00000000 @addr0, done; err cleared by next start.
REQ-035 start,length=0 -> done pulse next cycle, busy never asserts, in_ready stays 0.
REQ-036 length=3, rst asserted after first output fire -> all outputs 0 next cycle, no done; a fresh start,length=1 then emits @addr0.
REQ-037 Random in_valid/out_ready, length=100 -> exactly 100 output fires, addrs 0..99 in order, words match REQ-017 model.
